// File: rtl/switch_integrity_monitor_if.sv
// ============================================================================
// Module      : switch_integrity_monitor_if
// Description : Tap and readout bundle between a switch and its integrity monitor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface switch_integrity_monitor_if #(
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 16
);
    localparam int SEL_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]           valid_in;
    logic [NUM_PORTS*NUM_PORTS-1:0] target_in;
    logic [NUM_PORTS-1:0]           fifo_full;
    logic [NUM_PORTS-1:0]           fifo_empty;
    logic [NUM_PORTS-1:0]           valid_out;
    logic                           clear;
    logic                           snap_req;
    logic [SEL_W-1:0]               rd_sel;
    logic [CNT_W-1:0]               rd_accepted;
    logic [CNT_W-1:0]               rd_dropped;
    logic [CNT_W-1:0]               rd_delivered;
    logic                           snap_valid;
    logic signed [CNT_W+SEL_W:0]    in_flight;
    logic                           sat_any;
    logic                           leak_err;
    logic                           underflow_err;

    modport master (
        output valid_in, target_in, fifo_full, fifo_empty, valid_out,
        output clear, snap_req, rd_sel,
        input  rd_accepted, rd_dropped, rd_delivered, snap_valid,
        input  in_flight, sat_any, leak_err, underflow_err
    );

    modport slave (
        input  valid_in, target_in, fifo_full, fifo_empty, valid_out,
        input  clear, snap_req, rd_sel,
        output rd_accepted, rd_dropped, rd_delivered, snap_valid,
        output in_flight, sat_any, leak_err, underflow_err
    );
endinterface

`default_nettype wire

// File: rtl/switch_integrity_monitor.sv
// ============================================================================
// Module      : switch_integrity_monitor
// Description : Per-port saturating traffic counters with snapshot, in-flight
//               tracking and sticky leak / underflow detection.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module switch_integrity_monitor #(
    parameter int NUM_PORTS    = 4,
    parameter int CNT_W        = 16,
    parameter int QUIET_CYCLES = 64
) (
    input  wire logic                clk,
    input  wire logic                rst,
    switch_integrity_monitor_if.slave bus
);
    localparam int c_SEL_W = $clog2(NUM_PORTS);
    localparam int c_IF_W  = CNT_W + c_SEL_W + 1;
    localparam int c_POP_W = $clog2(NUM_PORTS + 1);
    localparam int c_Q_W   = $clog2(QUIET_CYCLES + 1);
    localparam logic [c_Q_W-1:0] c_QUIET_MAX = c_Q_W'(QUIET_CYCLES);

    logic [CNT_W-1:0] r_acc [NUM_PORTS];
    logic [CNT_W-1:0] r_drop[NUM_PORTS];
    logic [CNT_W-1:0] r_dlv [NUM_PORTS];
    logic [CNT_W-1:0] r_sh_acc [NUM_PORTS];
    logic [CNT_W-1:0] r_sh_drop[NUM_PORTS];
    logic [CNT_W-1:0] r_sh_dlv [NUM_PORTS];

    logic [c_POP_W-1:0]      w_pop     [NUM_PORTS];
    logic [CNT_W:0]          w_acc_res [NUM_PORTS];
    logic [CNT_W:0]          w_drop_res[NUM_PORTS];
    logic [CNT_W:0]          w_dlv_res [NUM_PORTS];
    logic                    w_sat_hit;
    logic                    w_sat_ad_hit;
    logic signed [c_IF_W-1:0] w_sum;
    logic                    w_quiet;

    logic signed [c_IF_W-1:0] r_in_flight;
    logic [c_Q_W-1:0]         r_quiet;
    logic                     r_sat_any;
    logic                     r_sat_ad;
    logic                     r_leak;
    logic                     r_uflow;
    logic                     r_snap_valid;

    // Returns {saturated, result}; the result clamps at all-ones.
    function automatic logic [CNT_W:0] f_sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [c_POP_W-1:0] inc);
        logic [CNT_W+c_POP_W-1:0] s;
        s = {{c_POP_W{1'b0}}, cnt} + {{CNT_W{1'b0}}, inc};
        if (|s[CNT_W+c_POP_W-1:CNT_W])
            f_sat_add = {1'b1, {CNT_W{1'b1}}};
        else
            f_sat_add = {1'b0, s[CNT_W-1:0]};
    endfunction

    always_comb begin
        w_sat_hit    = 1'b0;
        w_sat_ad_hit = 1'b0;
        w_sum        = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_pop[p] = '0;
            for (int b = 0; b < NUM_PORTS; b++)
                w_pop[p] = w_pop[p] + {{(c_POP_W-1){1'b0}}, bus.target_in[p*NUM_PORTS+b]};
            w_acc_res[p]  = f_sat_add(r_acc[p],
                                (bus.valid_in[p] && !bus.fifo_full[p]) ? w_pop[p] : '0);
            w_drop_res[p] = f_sat_add(r_drop[p],
                                (bus.valid_in[p] &&  bus.fifo_full[p]) ? w_pop[p] : '0);
            w_dlv_res[p]  = f_sat_add(r_dlv[p], {{(c_POP_W-1){1'b0}}, bus.valid_out[p]});
            w_sat_ad_hit  = w_sat_ad_hit | w_acc_res[p][CNT_W] | w_dlv_res[p][CNT_W];
            w_sat_hit     = w_sat_hit | w_acc_res[p][CNT_W] | w_drop_res[p][CNT_W]
                                      | w_dlv_res[p][CNT_W];
            w_sum = w_sum + $signed({{(c_IF_W-CNT_W){1'b0}}, r_acc[p]})
                          - $signed({{(c_IF_W-CNT_W){1'b0}}, r_dlv[p]});
        end
        w_quiet = (&bus.fifo_empty) && !(|bus.valid_out) && (r_in_flight > 0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_acc[p]     <= '0;
                r_drop[p]    <= '0;
                r_dlv[p]     <= '0;
                r_sh_acc[p]  <= '0;
                r_sh_drop[p] <= '0;
                r_sh_dlv[p]  <= '0;
            end
            r_in_flight  <= '0;
            r_quiet      <= '0;
            r_sat_any    <= 1'b0;
            r_sat_ad     <= 1'b0;
            r_leak       <= 1'b0;
            r_uflow      <= 1'b0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= bus.snap_req;
            // Shadows take the pre-event, pre-clear live values.
            if (bus.snap_req) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    r_sh_acc[p]  <= r_acc[p];
                    r_sh_drop[p] <= r_drop[p];
                    r_sh_dlv[p]  <= r_dlv[p];
                end
            end
            if (bus.clear) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    r_acc[p]  <= '0;
                    r_drop[p] <= '0;
                    r_dlv[p]  <= '0;
                end
                r_in_flight <= '0;
                r_quiet     <= '0;
                r_sat_any   <= 1'b0;
                r_sat_ad    <= 1'b0;
                r_leak      <= 1'b0;
                r_uflow     <= 1'b0;
            end else begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    r_acc[p]  <= w_acc_res[p][CNT_W-1:0];
                    r_drop[p] <= w_drop_res[p][CNT_W-1:0];
                    r_dlv[p]  <= w_dlv_res[p][CNT_W-1:0];
                end
                if (w_sat_hit)    r_sat_any <= 1'b1;
                if (w_sat_ad_hit) r_sat_ad  <= 1'b1;
                // A saturated acc/dlv counter makes the balance meaningless: freeze it.
                if (!r_sat_ad) begin
                    r_in_flight <= w_sum;
                    if (w_sum < 0) r_uflow <= 1'b1;
                    if (!w_quiet)
                        r_quiet <= '0;
                    else if (r_quiet != c_QUIET_MAX)
                        r_quiet <= r_quiet + 1'b1;
                    if (w_quiet && (r_quiet == c_QUIET_MAX - 1'b1)) r_leak <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.rd_accepted  = '0;
        bus.rd_dropped   = '0;
        bus.rd_delivered = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.rd_sel == c_SEL_W'(p)) begin
                bus.rd_accepted  = r_sh_acc[p];
                bus.rd_dropped   = r_sh_drop[p];
                bus.rd_delivered = r_sh_dlv[p];
            end
        end
    end

    assign bus.snap_valid    = r_snap_valid;
    assign bus.in_flight     = r_in_flight;
    assign bus.sat_any       = r_sat_any;
    assign bus.leak_err      = r_leak;
    assign bus.underflow_err = r_uflow;

endmodule

`default_nettype wire

// File: tb/tb_switch_integrity_monitor.sv
// ============================================================================
// Module      : tb_switch_integrity_monitor
// Description : Scoreboard bench for switch_integrity_monitor (4 ports, 4-bit counters).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_switch_integrity_monitor;
    localparam int NP   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    switch_integrity_monitor_if #(.NUM_PORTS(NP), .CNT_W(CW)) bus ();

    switch_integrity_monitor #(.NUM_PORTS(NP), .CNT_W(CW), .QUIET_CYCLES(64)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int acc [NP];
        int drop[NP];
        int dlv [NP];
    } snap_t;

    snap_t sb_q[$];
    int m_acc [NP];
    int m_drop[NP];
    int m_dlv [NP];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int p = 0; p < NP; p++) begin
            m_acc[p] = 0; m_drop[p] = 0; m_dlv[p] = 0;
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // One clock of stimulus; the model follows the edge, snapshots are queued pre-edge.
    task automatic drive_cycle(input logic [NP-1:0] vin, input logic [NP*NP-1:0] tgt,
                               input logic [NP-1:0] full, input logic [NP-1:0] vout,
                               input logic clr, input logic snap);
        snap_t s;
        bus.valid_in  = vin;
        bus.target_in = tgt;
        bus.fifo_full = full;
        bus.valid_out = vout;
        bus.clear     = clr;
        bus.snap_req  = snap;
        if (snap) begin
            for (int p = 0; p < NP; p++) begin
                s.acc[p] = m_acc[p]; s.drop[p] = m_drop[p]; s.dlv[p] = m_dlv[p];
            end
            sb_q.push_back(s);
        end
        tick();
        if (clr) model_zero();
        else begin
            for (int p = 0; p < NP; p++) begin
                logic [NP-1:0] mask;
                mask = tgt[p*NP +: NP];
                if (vin[p] && !full[p]) m_acc[p]  = sat(m_acc[p]  + $countones(mask));
                if (vin[p] &&  full[p]) m_drop[p] = sat(m_drop[p] + $countones(mask));
                if (vout[p])            m_dlv[p]  = sat(m_dlv[p] + 1);
            end
        end
        bus.valid_in = '0; bus.target_in = '0; bus.fifo_full = '0;
        bus.valid_out = '0; bus.clear = 1'b0; bus.snap_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle('0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // Issue a snapshot, then pop the expected record when snap_valid shows up.
    task automatic snap_and_check(input string tag);
        snap_t e;
        drive_cycle('0, '0, '0, '0, 1'b0, 1'b1);
        chk_eq({tag, "_snap_valid"}, 32'(bus.snap_valid), 1);
        e = sb_q.pop_front();
        for (int p = 0; p < NP; p++) begin
            bus.rd_sel = 2'(p);
            #1;
            chk_eq($sformatf("%s_acc%0d", tag, p), 32'(bus.rd_accepted),  e.acc[p]);
            chk_eq($sformatf("%s_drp%0d", tag, p), 32'(bus.rd_dropped),   e.drop[p]);
            chk_eq($sformatf("%s_dlv%0d", tag, p), 32'(bus.rd_delivered), e.dlv[p]);
        end
        bus.rd_sel = '0;
    endtask

    task automatic check_flags(input string tag, input int f, input int sa,
                               input int lk, input int uf);
        chk_eq({tag, "_in_flight"}, 32'(bus.in_flight), f);
        chk_eq({tag, "_sat_any"},   32'(bus.sat_any), sa);
        chk_eq({tag, "_leak"},      32'(bus.leak_err), lk);
        chk_eq({tag, "_uflow"},     32'(bus.underflow_err), uf);
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_in = '0; bus.target_in = '0; bus.fifo_full = '0; bus.fifo_empty = '0;
        bus.valid_out = '0; bus.clear = 1'b0; bus.snap_req = 1'b0; bus.rd_sel = '0;
        model_zero();
        repeat (3) tick();
        rst = 1'b0;
        check_flags("reset", 0, 0, 0, 0);
        chk_eq("reset_snap_valid", 32'(bus.snap_valid), 0);
        snap_and_check("reset");
        idle(1);
        chk_eq("snap_valid_drop", 32'(bus.snap_valid), 0);

        // Accept path: 3 x mask 1110 on port 0
        for (int i = 0; i < 3; i++) drive_cycle(4'b0001, 16'h000E, '0, '0, 1'b0, 1'b0);
        idle(2);
        chk_eq("accept_in_flight", 32'(bus.in_flight), 9);
        snap_and_check("accept");
        for (int i = 0; i < 9; i++) drive_cycle('0, '0, '0, 4'(2 << (i % 3)), 1'b0, 1'b0);
        idle(2);
        check_flags("delivered", 0, 0, 0, 0);

        // Drop path: 2 x mask 1111 on port 2 into a full FIFO
        for (int i = 0; i < 2; i++) drive_cycle(4'b0100, 16'h0F00, 4'b0100, '0, 1'b0, 1'b0);
        idle(2);
        chk_eq("drop_in_flight", 32'(bus.in_flight), 0);
        snap_and_check("drop");

        // Leak: one packet stranded, everything quiet
        drive_cycle('0, '0, '0, '0, 1'b1, 1'b0);
        idle(2);
        bus.fifo_empty = 4'hF;
        drive_cycle(4'b0001, 16'h0001, '0, '0, 1'b0, 1'b0);
        repeat (64) tick();
        check_flags("leak_pre", 1, 0, 0, 0);
        tick();
        chk_eq("leak_set", 32'(bus.leak_err), 1);

        // Leak restart: a delivery inside the window restarts the count
        drive_cycle('0, '0, '0, '0, 1'b1, 1'b0);
        idle(2);
        chk_eq("leak_cleared", 32'(bus.leak_err), 0);
        drive_cycle(4'b0001, 16'h0003, '0, '0, 1'b0, 1'b0);
        repeat (31) tick();
        drive_cycle('0, '0, '0, 4'b0010, 1'b0, 1'b0);
        repeat (63) tick();
        check_flags("restart_pre", 1, 0, 0, 0);
        tick();
        chk_eq("restart_set", 32'(bus.leak_err), 1);

        // Mid-operation reset clears everything, shadows included
        bus.fifo_empty = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_zero();
        check_flags("midrst", 0, 0, 0, 0);
        bus.rd_sel = 2'd0;
        #1;
        chk_eq("midrst_shadow_acc0", 32'(bus.rd_accepted), 0);

        // Underflow: phantom delivery on port 3
        drive_cycle('0, '0, '0, 4'b1000, 1'b0, 1'b0);
        tick();
        check_flags("uflow", -1, 0, 0, 1);
        drive_cycle('0, '0, '0, '0, 1'b1, 1'b0);
        idle(2);
        check_flags("uflow_clr", 0, 0, 0, 0);
        snap_and_check("uflow_clr");

        // Simultaneous snap_req + clear + accept with acc[0]=5
        for (int i = 0; i < 5; i++) drive_cycle(4'b0001, 16'h0001, '0, '0, 1'b0, 1'b0);
        drive_cycle(4'b0001, 16'h0003, '0, '0, 1'b1, 1'b1);
        chk_eq("simul_snap_valid", 32'(bus.snap_valid), 1);
        bus.rd_sel = 2'd0;
        #1;
        chk_eq("simul_shadow_acc0", 32'(bus.rd_accepted), 5);
        void'(sb_q.pop_front());
        snap_and_check("simul_live");

        // Saturation: 20 single-target accepts on port 1, CNT_W=4
        bus.fifo_empty = 4'hF;
        for (int i = 0; i < 20; i++) drive_cycle(4'b0010, 16'h0010, '0, '0, 1'b0, 1'b0);
        idle(2);
        check_flags("sat", 15, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive_cycle('0, '0, '0, 4'b0010, 1'b0, 1'b0);
        idle(70);
        check_flags("sat_frozen", 15, 1, 0, 0);
        snap_and_check("sat");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

`default_nettype wire
